alu_staged_iter: RTL

//  Parametrised next-generation staged ALU for the datapath: A staging register, G result register, tri-state RES onto the bus.

---
 rtl/alu_staged_iter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_staged_iter.sv
// Staged ALU: A staging register, G result register, tri-state RES, registered flags,
// single-cycle arithmetic/logic plus bit-serial shifts and multiply with BUSY/DONE.
module alu_staged_iter #(
  parameter  int WIDTH = 10,
  parameter  int IMM_W = 6,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] OP,
  input  logic [3:0]       FN,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             Gout,
  output logic [WIDTH-1:0] RES,
  output logic [3:0]       FLAGS,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [3:0] FN_LOAD = 4'h0, FN_COPY = 4'h1, FN_ADD  = 4'h2, FN_SUB  = 4'h3,
                         FN_INV  = 4'h4, FN_FLIP = 4'h5, FN_AND  = 4'h6, FN_OR   = 4'h7,
                         FN_XOR  = 4'h8, FN_LSL  = 4'h9, FN_LSR  = 4'hA, FN_ASR  = 4'hB,
                         FN_ADDI = 4'hC, FN_SUBI = 4'hD, FN_MUL  = 4'hE;
  localparam logic [WIDTH-1:0] W_OP  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
  localparam int M = WIDTH - 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, g_q, g_d, work_q, work_d, hi_q, hi_d, opnd_q, opnd_d;
  logic [3:0]       flags_q, flags_d, fn_q, fn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cy_q, cy_d, done_q, done_d;

  logic [WIDTH-1:0] imm, x, y, r;
  logic [WIDTH:0]   sum, madd;
  logic             cin, is_arith, iter_fn;

  assign imm     = {{(WIDTH - IMM_W){1'b0}}, OP[IMM_W-1:0]};
  assign iter_fn = (FN == FN_LSL) || (FN == FN_LSR) || (FN == FN_ASR) || (FN == FN_MUL);
  assign madd    = {1'b0, hi_q} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});

  // Shared adder: subtraction forms are x + ~y + 1 so C means "no borrow".
  always_comb begin
    x        = a_q;
    y        = OP;
    cin      = 1'b0;
    is_arith = 1'b1;
    case (FN)
      FN_SUB:  begin y = ~OP; cin = 1'b1; end
      FN_INV:  begin x = '0; y = ~OP; cin = 1'b1; end
      FN_ADDI: y = imm;
      FN_SUBI: begin y = ~imm; cin = 1'b1; end
      FN_ADD:  ;
      default: is_arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    case (FN)
      FN_LOAD: r = OP;
      FN_COPY: r = a_q;
      FN_FLIP: r = ~a_q;
      FN_AND:  r = a_q & OP;
      FN_OR:   r = a_q | OP;
      FN_XOR:  r = a_q ^ OP;
      default: r = is_arith ? sum[WIDTH-1:0] : '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = Ain ? OP : a_q;
    g_d     = g_q;
    flags_d = flags_q;
    work_d  = work_q;
    hi_d    = hi_q;
    opnd_d  = opnd_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Gin && iter_fn) begin
          state_d = S_RUN;
          work_d  = a_q;
          hi_d    = '0;
          opnd_d  = OP;
          fn_d    = FN;
          cy_d    = 1'b0;
          if (FN == FN_MUL) cnt_d = W_CNT;
          else              cnt_d = (OP >= W_OP) ? W_CNT : OP[CNT_W-1:0];
        end else if (Gin) begin
          g_d     = r;
          flags_d = {(r == '0), r[M],
                     is_arith & sum[WIDTH],
                     is_arith & (x[M] == y[M]) & (sum[M] != x[M])};
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          g_d     = work_q;
          done_d  = 1'b1;
          if (fn_q == FN_MUL) flags_d = {(work_q == '0), work_q[M], |hi_q, |hi_q};
          else                flags_d = {(work_q == '0), work_q[M], cy_q, 1'b0};
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (fn_q)
            FN_LSL: begin cy_d = work_q[M]; work_d = {work_q[M-1:0], 1'b0}; end
            FN_LSR: begin cy_d = work_q[0]; work_d = {1'b0, work_q[M:1]}; end
            FN_ASR: begin cy_d = work_q[0]; work_d = {work_q[M], work_q[M:1]}; end
            default: begin
              // Shift-add: {hi, work} shifts right as multiplier bits are consumed.
              hi_d   = madd[WIDTH:1];
              work_d = {madd[0], work_q[M:1]};
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge CLKb) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      work_q  <= '0;
      hi_q    <= '0;
      opnd_q  <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      g_q     <= g_d;
      flags_q <= flags_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      opnd_q  <= opnd_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
    end
  end

  assign RES   = Gout ? g_q : {WIDTH{1'bz}};
  assign FLAGS = flags_q;
  assign BUSY  = (state_q == S_RUN);
  assign DONE  = done_q;

endmodule
